mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the processor MEM stage and datamem. Accepts one
//  byte/half/word request at a time and drives datamem's byte-addressed, big-endian,
//  word-wide ports. Sub-word stores use read-modify-write, because datamem always
//  writes 4 bytes. Returns sign- or zero-extended load data.
// PARAMETERS
//  WORD_WIDTH  32  data/address width; only 32 is supported
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  req         in   1   request strobe; sampled only in IDLE
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00=byte, 01=half, 10=word, 11=reserved (treated as word)
//  req_uns     in   1   load zero-extends when 1, sign-extends when 0
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; byte=[7:0], half=[15:0]
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle completion pulse
//  err         out  1   pulses with done on a trapped access (MISALIGN_TRAP_EN only)
//  rdata       out  32  extended load data; valid while done=1, held until next load
//  data_addr   out  32  to datamem; = addr_q
//  data_wr     out  1   to datamem write enable; high only in WRITE
//  data_in     out  32  to datamem; = wdata_q (merged word)
//  data_out    in   32  from datamem; combinational read of addr..addr+3
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, data_wr = 0; rdata, addr_q, wdata_q = 0.
//  States: IDLE, LOAD, RMW_RD, WRITE, DONE.
//  IDLE: if req, capture addr/size/uns/we/wdata into the _q registers. Next state:
//   load -> LOAD; word store -> WRITE with wdata_q=req_wdata; sub-word store -> RMW_RD.
//  LOAD: rdata <= extend(slice of data_out); next state DONE.
//   Big-endian slices: byte = data_out[31:24]; half = data_out[31:16]; word = data_out.
//  RMW_RD: wdata_q <= data_out with the high slice replaced.
//   Byte store: [31:24] = wdata_q[7:0]. Half store: [31:16] = wdata_q[15:0].
//   The low bytes are kept from data_out. Next state WRITE.
//  WRITE: data_wr=1 for exactly one cycle; next state DONE.
//  DONE: done=1 for one cycle; next state IDLE. A new req is accepted in the
//   following IDLE cycle; there is no back-to-back acceptance in DONE.
//  Latency from the req-sample edge to the done cycle:
//   load 2 cycles; word store 2 cycles; byte/half store 3 cycles.
//  data_addr is stable from the first busy cycle through DONE.
//  req while busy: ignored and not queued. The master holds req until done.
//  Address wrap: addr+1..+3 beyond datamem depth is datamem's concern; no checking here.
//  Reset mid-op: returns to IDLE at the next edge and no done is issued. If rst and
//   WRITE coincide, the datamem write at that edge still occurs; no partial write is
//   possible.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   Half with addr[0]=1, word/reserved with addr[1:0]!=0 -> IDLE goes directly to DONE.
//   In that case done=err=1, rdata unchanged, data_wr never asserted. Latency 1 cycle.
//  MISALIGN_TRAP_EN undefined:
//   err tied 0. Misaligned accesses proceed normally, because datamem is byte-addressed.
// TESTING
//  1 Reset: hold rst 2 cycles -> busy=done=data_wr=0, rdata=0, data_addr=0.
//  2 Mem[0x10..13]=80 11 22 33; load byte signed @0x10
//    -> done at +2, rdata=FFFFFF80; unsigned -> 00000080.
//  3 Word store 0xDEADBEEF @0x20 -> data_wr one cycle at +1, done at +2;
//    reading back 0x20 gives DEADBEEF.
//  4 Mem[0x30..33]=AA BB CC DD; store half 0x1234 @0x30
//    -> RMW: data_in=1234CCDD, done at +3; bytes 0x32/0x33 unchanged.
//  5 Assert rst during RMW_RD -> no data_wr, no done, IDLE next cycle;
//    memory unchanged.
//  6 Word load @0x21: MISALIGN_TRAP_EN -> done=err=1 at +1, data_wr=0;
//    without the macro -> normal load of bytes 0x21..0x24.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response bus between the MEM stage and mem_access_unit
//
// Purpose: groups the processor-side load/store request and its completion
// signals so that the requester and the sequencer share one bundle.
// Signals:
//   req        request strobe, held by the master until done
//   req_we     1=store, 0=load
//   req_size   00=byte, 01=half, 10=word, 11=word
//   req_uns    zero-extend loads when 1
//   req_addr   byte address
//   req_wdata  store data, right-aligned for sub-word sizes
//   busy       sequencer not idle
//   done       one-cycle completion pulse
//   err        trapped access flag, valid with done
//   rdata      extended load data
// Modports: master = requester (MEM stage), slave = mem_access_unit.

interface mem_access_unit_if;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, req_we, req_size, req_uns, req_addr, req_wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, req_we, req_size, req_uns, req_addr, req_wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between the MEM stage and a word-wide big-endian datamem
//
// Purpose: accepts one byte/half/word request at a time, performs loads with
// sign/zero extension and sub-word stores by read-modify-write.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        mem_access_unit_if.slave request/response bundle
//   data_addr  byte address to datamem (captured request address)
//   data_wr    datamem write enable, asserted only in WRITE
//   data_in    merged word written to datamem
//   data_out   combinational datamem read of data_addr..data_addr+3
// Configuration: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (done and err pulse after one cycle, no memory access).

module mem_access_unit #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_unit_if.slave      bus,
    output logic [WORD_WIDTH-1:0] data_addr,
    output logic                  data_wr,
    output logic [WORD_WIDTH-1:0] data_in,
    input  logic [WORD_WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic        trap;
    logic [31:0] load_ext;

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0]=0; word and the reserved size need 4-byte alignment.
    assign trap = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                  (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // datamem is big-endian, so the addressed byte/half is the top of data_out.
    always_comb begin
        load_ext = data_out;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, data_out[31:24]}
                                      : {{24{data_out[31]}}, data_out[31:24]};
            2'b01:   load_ext = uns_q ? {16'h0, data_out[31:16]}
                                      : {{16{data_out[31]}}, data_out[31:16]};
            default: load_ext = data_out;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_uns;
                    wdata_d = bus.req_wdata;
                    err_d   = trap;
                    if (trap)
                        state_d = S_DONE;
                    else if (!bus.req_we)
                        state_d = S_LOAD;
                    else if (bus.req_size[1])
                        state_d = S_WRITE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                // Only byte or half reach here; the new data replaces the high
                // slice and the remaining low bytes come from memory.
                if (size_q[0])
                    wdata_d = {wdata_q[15:0], data_out[15:0]};
                else
                    wdata_d = {wdata_q[7:0], data_out[23:0]};
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = (state_q == S_DONE);
    assign bus.err   = (state_q == S_DONE) && err_q;
    assign bus.rdata = rdata_q;
    assign data_wr   = (state_q == S_WRITE);
    assign data_addr = addr_q;
    assign data_in   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_addr, data_in, data_out;
    logic        data_wr;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .data_addr (data_addr),
        .data_wr   (data_wr),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    // Behavioural datamem: 256 bytes, big-endian, address wraps at 8 bits.
    logic [7:0] mem [256];

    always_comb begin
        logic [7:0] a;
        a = data_addr[7:0];
        data_out = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    end

    always @(posedge clk) begin
        logic [7:0] a;
        a = data_addr[7:0];
        if (data_wr) begin
            mem[a]        <= data_in[31:24];
            mem[a + 8'd1] <= data_in[23:16];
            mem[a + 8'd2] <= data_in[15:8];
            mem[a + 8'd3] <= data_in[7:0];
        end
    end

    // Reference model state: byte image and last load result.
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_rdata;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++)
            w = (w << 8) | 32'(ref_mem[a + 8'(i)]);
        return w;
    endfunction

    // Transaction-level model: byte array updates and arithmetic extension.
    task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic err, output int wr,
                            output logic [31:0] din, output logic [31:0] rd);
        logic [7:0] a;
        logic       mis;
        logic       trap;
        int         nbytes;
        int         val;
        a      = addr[7:0];
        mis    = ((size == 2'd1) && addr[0]) || ((size >= 2'd2) && (addr % 4 != 0));
`ifdef MISALIGN_TRAP_EN
        trap   = mis;
`else
        trap   = 1'b0;
        if (mis) trap = 1'b0;
`endif
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        din    = 32'h0;
        err    = 1'b0;
        wr     = 0;
        if (trap) begin
            lat = 1;
            err = 1'b1;
        end else if (!we) begin
            lat = 2;
            if (nbytes == 4) begin
                ref_rdata = ref_word(a);
            end else begin
                val = 0;
                for (int i = 0; i < nbytes; i++)
                    val = val * 256 + int'(ref_mem[a + 8'(i)]);
                if (!uns && val >= (1 << (8 * nbytes - 1)))
                    val = val - (1 << (8 * nbytes));
                ref_rdata = 32'(val);
            end
        end else begin
            lat = (nbytes == 4) ? 2 : 3;
            wr  = 1;
            for (int i = 0; i < nbytes; i++)
                ref_mem[a + 8'(i)] = 8'((wdata >> (8 * (nbytes - 1 - i))) & 32'hFF);
            din = ref_word(a);
        end
        rd = ref_rdata;
    endtask

    task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input int exp_wr,
                          input logic [31:0] exp_din, input logic [31:0] exp_rd);
        int          lat;
        int          wr_cnt;
        logic [31:0] din_seen;
        logic [31:0] rd_seen;
        logic        err_seen;
        logic        addr_ok;
        @(negedge clk);
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_uns   = uns;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        lat      = 0;
        wr_cnt   = 0;
        din_seen = 32'h0;
        rd_seen  = 32'h0;
        err_seen = 1'b0;
        addr_ok  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || data_addr !== addr) addr_ok = 1'b0;
            if (data_wr === 1'b1) begin
                wr_cnt++;
                din_seen = data_in;
            end
            if (bus.done === 1'b1) begin
                lat      = k;
                err_seen = bus.err;
                rd_seen  = bus.rdata;
                break;
            end
        end
        bus.req = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " err"}, {31'h0, err_seen}, {31'h0, exp_err});
        chk({tag, " rdata"}, rd_seen, exp_rd);
        chk({tag, " write count"}, 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr != 0)
            chk({tag, " data_in"}, din_seen, exp_din);
        chk({tag, " addr/busy stable"}, {31'h0, addr_ok}, 32'h1);
        @(negedge clk);
        chk({tag, " idle after done"}, {30'h0, bus.busy, bus.done}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        int          wr;
        logic [31:0] din;
        logic [31:0] rd;
    } vec_t;

    vec_t tab [16];

    initial begin
        int          m_lat, m_wr, mism;
        logic        m_err, ok;
        logic [31:0] m_din, m_rd;

        bus.req = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_uns = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[8'h10] = 8'h80; mem[8'h11] = 8'h11; mem[8'h12] = 8'h22; mem[8'h13] = 8'h33;
        mem[8'h30] = 8'hAA; mem[8'h31] = 8'hBB; mem[8'h32] = 8'hCC; mem[8'h33] = 8'hDD;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        ref_rdata = 32'h0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'h0, bus.busy}, 32'h0);
        chk("reset done", {31'h0, bus.done}, 32'h0);
        chk("reset err", {31'h0, bus.err}, 32'h0);
        chk("reset data_wr", {31'h0, data_wr}, 32'h0);
        chk("reset rdata", bus.rdata, 32'h0);
        chk("reset data_addr", data_addr, 32'h0);
        rst = 1'b0;

        //         we    size   uns   addr    wdata         lat err  wr din           rd
        tab[0]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        2, 1'b0, 0, 32'h0,        32'hFFFFFF80};
        tab[1]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        2, 1'b0, 0, 32'h0,        32'h00000080};
        tab[2]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        2, 1'b0, 0, 32'h0,        32'hFFFF8011};
        tab[3]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        2, 1'b0, 0, 32'h0,        32'h80112233};
        tab[4]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 2, 1'b0, 1, 32'hDEADBEEF, 32'h80112233};
        tab[5]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        2, 1'b0, 0, 32'h0,        32'hDEADBEEF};
        tab[6]  = '{1'b1, 2'd1, 1'b0, 32'h30, 32'h00001234, 3, 1'b0, 1, 32'h1234CCDD, 32'hDEADBEEF};
        tab[7]  = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0,        2, 1'b0, 0, 32'h0,        32'h1234CCDD};
        tab[8]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 3, 1'b0, 1, 32'h5A223300, 32'h1234CCDD};
        tab[9]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        2, 1'b0, 0, 32'h0,        32'h805A2233};
        tab[10] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        2, 1'b0, 0, 32'h0,        32'h00002233};
        tab[11] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        2, 1'b0, 0, 32'h0,        32'hDEADBEEF};
`ifdef MISALIGN_TRAP_EN
        tab[12] = '{1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        1, 1'b1, 0, 32'h0,        32'hDEADBEEF};
        tab[13] = '{1'b0, 2'd1, 1'b0, 32'h31, 32'h0,        1, 1'b1, 0, 32'h0,        32'hDEADBEEF};
        tab[14] = '{1'b1, 2'd2, 1'b0, 32'h22, 32'h11223344, 1, 1'b1, 0, 32'h0,        32'hDEADBEEF};
        tab[15] = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        2, 1'b0, 0, 32'h0,        32'h000000EF};
`else
        tab[12] = '{1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        2, 1'b0, 0, 32'h0,        32'hADBEEF00};
        tab[13] = '{1'b0, 2'd1, 1'b0, 32'h31, 32'h0,        2, 1'b0, 0, 32'h0,        32'h000034CC};
        tab[14] = '{1'b1, 2'd2, 1'b0, 32'h22, 32'h11223344, 2, 1'b0, 1, 32'h11223344, 32'h000034CC};
        tab[15] = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        2, 1'b0, 0, 32'h0,        32'h00000022};
`endif

        for (int i = 0; i < 16; i++) begin
            model_op(tab[i].we, tab[i].size, tab[i].uns, tab[i].addr, tab[i].wdata,
                     m_lat, m_err, m_wr, m_din, m_rd);
            run_op($sformatf("tab%0d", i), tab[i].we, tab[i].size, tab[i].uns,
                   tab[i].addr, tab[i].wdata, tab[i].lat, tab[i].err, tab[i].wr,
                   tab[i].din, tab[i].rd);
        end

        // Reset during RMW_RD: no write, no done, memory untouched.
        @(negedge clk);
        bus.req = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_uns = 1'b0;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        chk("rmw busy before reset", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        bus.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset busy", {31'h0, bus.busy}, 32'h0);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.done !== 1'b0 || data_wr !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("midreset no done/write", {31'h0, ok}, 32'h1);
        chk("midreset rdata", bus.rdata, 32'h0);
        chk("midreset data_addr", data_addr, 32'h0);
        chk("midreset mem 0x40", {24'h0, mem[8'h40]}, 32'h0);
        ref_rdata = 32'h0;

        // Randomized transactions against the model.
        for (int i = 0; i < 80; i++) begin
            logic        r_we, r_uns;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = 32'($urandom_range(0, 255));
            r_wdata = $urandom;
            model_op(r_we, r_size, r_uns, r_addr, r_wdata, m_lat, m_err, m_wr, m_din, m_rd);
            run_op($sformatf("rnd%0d", i), r_we, r_size, r_uns, r_addr, r_wdata,
                   m_lat, m_err, m_wr, m_din, m_rd);
        end

        mism = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        chk("final memory image mismatches", 32'(mism), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
